frame_tx_1011: RTL and testbench

//  Serial frame transmitter; the sending end of the 1011-preamble serial link.
//  - Accepts a parallel payload word over a valid/ready handshake.
//  - Emits the word one bit per clk: preamble 1011, payload MSB first, optional parity, then an idle gap.
//  - Drives the din input of the downstream Moore 1011 sequence detector and frame receiver.

---
 rtl/frame_tx_pkg.sv | 21 ++
 rtl/frame_tx_1011_piso_shreg.sv | 48 ++++
 rtl/frame_tx_1011.sv | 176 +++++++++++++++++
 tb/tb_frame_tx_1011.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_tx_pkg.sv
// Shared definitions for the 1011-preamble serial link (transmitter and receiver side).
package frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } frame_tx_state_t;

  localparam logic [3:0] PREAMBLE = 4'b1011;
  localparam int         PRE_LEN  = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_tx_1011_piso_shreg.sv
// Parallel-load, MSB-first shift register feeding the serial payload bits.
module piso_shreg
  import frame_tx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb,
  output logic              nxt_msb
);

  logic [DATA_W-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = shreg_q << 1;
    end else begin
      shreg_d = shreg_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[DATA_W-1];

  // nxt_msb is the bit that becomes msb after one shift; a 1-bit register has none.
  generate
    if (DATA_W > 1) begin : g_nxt
      assign nxt_msb = shreg_q[DATA_W-2];
    end else begin : g_nxt_none
      assign nxt_msb = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/frame_tx_1011.sv
// Serial frame transmitter: preamble 1011, payload MSB first, optional even parity
// (macro FRAME_TX_PARITY_EN), then an idle gap of GAP_CYCLES zeros.
module frame_tx_1011
  import frame_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              busy,
  output logic              tx_last
);

  localparam int             CNT_W     = $clog2(max3(DATA_W, GAP_CYCLES, PRE_LEN)) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  frame_tx_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             tx_last_q, tx_last_d;
  logic             accept;
  logic             load;
  logic             shift;
  logic             sh_msb;
  logic             sh_nxt;
  logic             par_bit;
  logic [1:0]       pre_idx;

  assign accept  = in_valid & (state_q == IDLE);
  assign cnt_inc = cnt_q + CNT_ONE;
  // Preamble bit index for the next cycle: cnt 0..2 selects PREAMBLE[2..0].
  assign pre_idx = 2'd2 - cnt_q[1:0];

`ifdef FRAME_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  logic parity_q, parity_d;

  // Parity is taken at accept because the shift register is consumed while sending.
  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^in_data;
    end else begin
      parity_d = parity_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign par_bit = parity_q;
`else
  localparam bit PAR_EN = 1'b0;
  assign par_bit = 1'b0;
`endif

  piso_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .din     (in_data),
    .msb     (sh_msb),
    .nxt_msb (sh_nxt)
  );

  // dout/tx_last are computed for the state being entered, so they register in step with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = 1'b0;
    tx_last_d = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PRE;
          cnt_d   = '0;
          dout_d  = PREAMBLE[PRE_LEN-1];
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d   = DATA;
          cnt_d     = '0;
          dout_d    = sh_msb;
          tx_last_d = !PAR_EN && (DATA_LAST == '0);
        end else begin
          cnt_d  = cnt_inc;
          dout_d = PREAMBLE[pre_idx];
        end
      end
      DATA: begin
        shift = 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d = '0;
          if (PAR_EN) begin
            state_d   = PAR;
            dout_d    = par_bit;
            tx_last_d = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d     = cnt_inc;
          dout_d    = sh_nxt;
          tx_last_d = !PAR_EN && (cnt_inc == DATA_LAST);
        end
      end
      PAR: begin
        cnt_d = '0;
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      tx_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      tx_last_q <= tx_last_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign tx_last  = tx_last_q;

endmodule

// File: tb/tb_frame_tx_1011.sv
// Bench for frame_tx_1011: scoreboard of expected per-cycle line values, two instances
// (8-bit/gap 2 and 1-bit/gap 0); follows FRAME_TX_PARITY_EN if defined.
`timescale 1ns/1ps
module tb_frame_tx_1011;

  localparam int W1 = 8;
  localparam int G1 = 2;
  localparam int W2 = 1;
  localparam int G2 = 0;
`ifdef FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data1;
  logic       in_valid1, in_ready1, dout1, busy1, tx_last1;
  logic [0:0] in_data2;
  logic       in_valid2, in_ready2, dout2, busy2, tx_last2;

  always #5 clk = ~clk;

  frame_tx_1011 #(.DATA_W(W1), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .dout(dout1), .busy(busy1), .tx_last(tx_last1)
  );

  frame_tx_1011 #(.DATA_W(W2), .GAP_CYCLES(G2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .dout(dout2), .busy(busy2), .tx_last(tx_last2)
  );

  typedef struct packed {
    logic dout;
    logic tx_last;
    logic busy;
    logic in_ready;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line for one frame: preamble, payload MSB first, parity if built, gap zeros.
  task automatic push_frame(input int which, input logic [7:0] data, input int w,
                            input int gap, input logic par);
    logic [3:0] pre;
    exp_t       e;
    pre = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      e = '{pre[i], 1'b0, 1'b1, 1'b0};
      if (which == 1) q1.push_back(e); else q2.push_back(e);
    end
    for (int i = w - 1; i >= 0; i--) begin
      e = '{data[i], (P == 0 && i == 0), 1'b1, 1'b0};
      if (which == 1) q1.push_back(e); else q2.push_back(e);
    end
    if (P == 1) begin
      e = '{par, 1'b1, 1'b1, 1'b0};
      if (which == 1) q1.push_back(e); else q2.push_back(e);
    end
    for (int i = 0; i < gap; i++) begin
      e = '{1'b0, 1'b0, 1'b1, 1'b0};
      if (which == 1) q1.push_back(e); else q2.push_back(e);
    end
  endtask

  task automatic mon_cmp(input string tag, input exp_t e, input logic d, input logic tl,
                         input logic b, input logic r);
    chk({tag, "_dout"}, d, e.dout);
    chk({tag, "_tx_last"}, tl, e.tx_last);
    chk({tag, "_busy"}, b, e.busy);
    chk({tag, "_in_ready"}, r, e.in_ready);
  endtask

  // Monitor: one expected entry per cycle; an empty queue means the line must be idle.
  initial begin
    exp_t e1, e2;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q1.size() > 0) e1 = q1.pop_front(); else e1 = '{1'b0, 1'b0, 1'b0, 1'b1};
        if (q2.size() > 0) e2 = q2.pop_front(); else e2 = '{1'b0, 1'b0, 1'b0, 1'b1};
        mon_cmp("d1", e1, dout1, tx_last1, busy1, in_ready1);
        mon_cmp("d2", e2, dout2, tx_last2, busy2, in_ready2);
      end
    end
  end

  task automatic send1(input logic [7:0] data, input logic par);
    int t;
    t = 0;
    while (!in_ready1 && t < 100) begin
      @(posedge clk); #3; t++;
    end
    chk("d1_ready_wait", in_ready1, 1);
    in_valid1 = 1'b1;
    in_data1  = data;
    push_frame(1, data, W1, G1, par);
    @(posedge clk); #3;
    in_valid1 = 1'b0;
    in_data1  = 8'($urandom);
  endtask

  task automatic send2(input logic data, input logic par);
    int t;
    t = 0;
    while (!in_ready2 && t < 100) begin
      @(posedge clk); #3; t++;
    end
    chk("d2_ready_wait", in_ready2, 1);
    in_valid2 = 1'b1;
    in_data2  = data;
    push_frame(2, {7'd0, data}, W2, G2, par);
    @(posedge clk); #3;
    in_valid2 = 1'b0;
    in_data2  = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q1.size() > 0 || q2.size() > 0) && t < 200) begin
      @(posedge clk); #3; t++;
    end
    chk("drain", q1.size() + q2.size(), 0);
    @(posedge clk); #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   cycles;
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'hFF, 1'b0};
    tbl[2] = '{8'h13, 1'b1};
    tbl[3] = '{8'h80, 1'b1};
    tbl[4] = '{8'h3C, 1'b0};
    tbl[5] = '{8'h01, 1'b1};

    // Reset held with in_valid asserted: line stays idle.
    rst = 1'b1; in_valid1 = 1'b1; in_data1 = 8'hA5; in_valid2 = 1'b1; in_data2 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_dout", dout1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_tx_last", tx_last1, 0);
      chk("rst_in_ready", in_ready1, 1);
      chk("rst_d2_dout", dout2, 0);
      #2;
    end
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #3;

    for (int i = 0; i < 6; i++) begin
      send1(tbl[i].data, tbl[i].par);
      drain();
    end

    // Back-to-back: in_valid held, data changed after accept, second accept after one frame period.
    in_valid1 = 1'b1;
    in_data1  = 8'hC3;
    push_frame(1, 8'hC3, W1, G1, 1'b0);
    @(posedge clk); #3;
    in_data1 = 8'h5A;
    cycles = 1;
    while (!in_ready1 && cycles < 100) begin
      @(posedge clk); #3; cycles++;
    end
    chk("b2b_period", cycles, 1 + 4 + W1 + P + G1);
    push_frame(1, 8'h5A, W1, G1, 1'b0);
    @(posedge clk); #3;
    in_valid1 = 1'b0;
    drain();

    // Reset mid-payload on the 4th data bit (a 1 for 8'h1F): line drops before any clock edge.
    send1(8'h1F, 1'b1);
    repeat (7) begin
      @(posedge clk); #3;
    end
    chk("mid_bit3_dout", dout1, 1);
    q1.delete();
    rst = 1'b1;
    #1;
    chk("async_rst_dout", dout1, 0);
    chk("async_rst_busy", busy1, 0);
    chk("async_rst_tx_last", tx_last1, 0);
    chk("async_rst_in_ready", in_ready1, 1);
    @(posedge clk); #2;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #3;
    chk("post_rst_in_ready", in_ready1, 1);
    chk("post_rst_busy", busy1, 0);
    send1(8'hA5, 1'b0);
    drain();

    // One-bit payload, no gap: frame then straight back to idle.
    send2(1'b1, 1'b1);
    drain();
    send2(1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
